// File: rtl/hdmi_cfg_pkg.sv
// Shared types and constants for the HDMI transmitter configuration sequencer.
package hdmi_cfg_pkg;

  typedef enum logic [3:0] {
    BOOT,
    LOAD,
    GO_HI,
    GO_LO,
    WAIT_BUSY,
    WAIT_DONE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] BYTE_NUM     = 8'd2;
  localparam int         WDOG_PERIODS = 64;

endpackage

// File: rtl/hdmi_cfg_rom.sv
// Register/value table for the HDMI transmitter; entries at or beyond LUT_SIZE read as zero.
module hdmi_cfg_rom #(
  parameter int LUT_SIZE = 31
) (
  input  logic [7:0]  idx,
  output logic [15:0] data
);

  always_comb begin
    data = '0;
    if (32'(idx) < LUT_SIZE) begin
      case (idx)
        8'd0:    data = 16'h9803;
        8'd1:    data = 16'h9AE0;
        8'd2:    data = 16'h9C30;
        8'd3:    data = 16'h9D61;
        8'd4:    data = 16'hA2A4;
        8'd5:    data = 16'hA3A4;
        8'd6:    data = 16'hE0D0;
        8'd7:    data = 16'hF900;
        8'd8:    data = 16'h4110;
        8'd9:    data = 16'h1500;
        8'd10:   data = 16'h1630;
        8'd11:   data = 16'h1702;
        8'd12:   data = 16'h1846;
        8'd13:   data = 16'hAF06;
        8'd14:   data = 16'h4080;
        8'd15:   data = 16'h4C04;
        8'd16:   data = 16'h5510;
        8'd17:   data = 16'h5608;
        8'd18:   data = 16'h9620;
        8'd19:   data = 16'hD03C;
        8'd20:   data = 16'hBA60;
        8'd21:   data = 16'hDE82;
        8'd22:   data = 16'hE4C0;
        8'd23:   data = 16'hE580;
        8'd24:   data = 16'h9403;
        8'd25:   data = 16'h9580;
        8'd26:   data = 16'hD6C0;
        8'd27:   data = 16'h3B80;
        8'd28:   data = 16'h3C00;
        8'd29:   data = 16'h4A80;
        8'd30:   data = 16'h4B00;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/hdmi_cfg_sequencer.sv
// Boot-time I2C register loader for an HDMI transmitter with per-entry retry and watchdog.
// Optional HDMI_CFG_HPD_EN: a hot-plug rising edge re-runs the whole table after DONE/ERROR.
module hdmi_cfg_sequencer
  import hdmi_cfg_pkg::*;
#(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         I2C_FREQ   = 20_000,
  parameter int         LUT_SIZE   = 31,
  parameter logic [7:0] SLAVE_ADDR = 8'h72,
  parameter int         MAX_RETRY  = 3,
  parameter int         BOOT_DLY   = 1_000_000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        I2C_CLK,
  output logic        I2C_GO,
  output logic [15:0] I2C_REG_DATA,
  output logic [7:0]  I2C_SLAVE_ADDR,
  output logic [7:0]  I2C_BYTE_NUM,
  input  logic        I2C_END_OK,
  input  logic        I2C_NACK,
  input  logic        HPD,
  output logic        CFG_DONE,
  output logic        CFG_ERR,
  output logic [7:0]  CFG_IDX
);

  localparam int          HALF_RAW    = CLK_FREQ / (2 * I2C_FREQ);
  localparam int          HALF        = (HALF_RAW > 0) ? HALF_RAW : 1;
  localparam logic [31:0] HALF_LAST   = 32'(HALF - 1);
  localparam logic [31:0] GO_LAST     = 32'(4 * HALF - 1);
  localparam logic [31:0] WDOG_LAST   = 32'(WDOG_PERIODS * 2 * HALF - 1);
  localparam logic [31:0] BOOT_CYCLES = 32'(BOOT_DLY);
  localparam int          RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]  LUT_END     = 8'(LUT_SIZE);

  assign I2C_SLAVE_ADDR = SLAVE_ADDR;
  assign I2C_BYTE_NUM   = BYTE_NUM;

  logic [31:0] div_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      div_cnt <= '0;
      I2C_CLK <= 1'b0;
    end else if (div_cnt == HALF_LAST) begin
      div_cnt <= '0;
      I2C_CLK <= ~I2C_CLK;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  logic [1:0] end_ok_sync;
  logic [1:0] nack_sync;
  logic       end_ok_s;
  logic       nack_s;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      end_ok_sync <= '0;
      nack_sync   <= '0;
    end else begin
      end_ok_sync <= {end_ok_sync[0], I2C_END_OK};
      nack_sync   <= {nack_sync[0], I2C_NACK};
    end
  end

  assign end_ok_s = end_ok_sync[1];
  assign nack_s   = nack_sync[1];

`ifdef HDMI_CFG_HPD_EN
  logic [2:0] hpd_sync;
  logic       hpd_rise;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) hpd_sync <= '0;
    else          hpd_sync <= {hpd_sync[1:0], HPD};
  end

  assign hpd_rise = hpd_sync[1] & ~hpd_sync[2];
`else
  logic unused_hpd;
  assign unused_hpd = HPD;
`endif

  logic [15:0] rom_data;

  hdmi_cfg_rom #(.LUT_SIZE(LUT_SIZE)) u_rom (
    .idx  (CFG_IDX),
    .data (rom_data)
  );

  state_t        state;
  logic [31:0]   cnt;
  logic [RW-1:0] retry_cnt;
  logic          retrying;
  logic          nack_seen;
`ifdef HDMI_CFG_HPD_EN
  logic          hpd_pend;
`endif

  // cnt is shared: boot delay, GO high time, then watchdog across both wait states.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= BOOT;
      cnt          <= '0;
      retry_cnt    <= '0;
      retrying     <= 1'b0;
      nack_seen    <= 1'b0;
      I2C_GO       <= 1'b0;
      I2C_REG_DATA <= '0;
      CFG_DONE     <= 1'b0;
      CFG_ERR      <= 1'b0;
      CFG_IDX      <= '0;
`ifdef HDMI_CFG_HPD_EN
      hpd_pend     <= 1'b0;
`endif
    end else begin
`ifdef HDMI_CFG_HPD_EN
      if (hpd_rise && state != DONE && state != ERROR) hpd_pend <= 1'b1;
`endif
      case (state)
        BOOT: begin
          CFG_IDX <= '0;
          if (cnt + 32'd1 >= BOOT_CYCLES) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LOAD: begin
          I2C_REG_DATA <= rom_data;
          if (!retrying) retry_cnt <= '0;
          retrying <= 1'b0;
          cnt      <= '0;
          I2C_GO   <= 1'b1;
          state    <= GO_HI;
        end
        GO_HI: begin
          if (cnt == GO_LAST) begin
            cnt    <= '0;
            I2C_GO <= 1'b0;
            state  <= GO_LO;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        GO_LO: begin
          I2C_GO <= 1'b0;
          cnt    <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (cnt == WDOG_LAST) begin
            nack_seen <= 1'b1;
            state     <= CHECK;
          end else begin
            cnt <= cnt + 32'd1;
            if (!end_ok_s) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (end_ok_s) begin
            nack_seen <= nack_s;
            state     <= CHECK;
          end else if (cnt == WDOG_LAST) begin
            nack_seen <= 1'b1;
            state     <= CHECK;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        CHECK: begin
          if (!nack_seen) begin
            if (CFG_IDX + 8'd1 >= LUT_END) begin
              CFG_IDX  <= LUT_END;
              CFG_DONE <= 1'b1;
              state    <= DONE;
            end else begin
              CFG_IDX <= CFG_IDX + 8'd1;
              state   <= LOAD;
            end
          end else if (retry_cnt < RETRY_MAX) begin
            retry_cnt <= retry_cnt + 1'b1;
            retrying  <= 1'b1;
            state     <= LOAD;
          end else begin
            CFG_ERR <= 1'b1;
            state   <= ERROR;
          end
        end
        DONE: begin
          CFG_DONE <= 1'b1;
`ifdef HDMI_CFG_HPD_EN
          if (hpd_rise || hpd_pend) begin
            hpd_pend <= 1'b0;
            CFG_DONE <= 1'b0;
            CFG_IDX  <= '0;
            cnt      <= '0;
            state    <= BOOT;
          end
`endif
        end
        ERROR: begin
          CFG_ERR <= 1'b1;
`ifdef HDMI_CFG_HPD_EN
          if (hpd_rise || hpd_pend) begin
            hpd_pend <= 1'b0;
            CFG_ERR  <= 1'b0;
            CFG_IDX  <= '0;
            cnt      <= '0;
            state    <= BOOT;
          end
`endif
        end
        default: begin
          I2C_GO <= 1'b0;
          state  <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// Randomized bench for hdmi_cfg_sequencer: behavioural I2C engine plus attempt-list reference model.
module tb_hdmi_cfg_sequencer;

  localparam int         CLK_FREQ   = 1000;
  localparam int         I2C_FREQ   = 100;
  localparam int         LUT_SIZE   = 3;
  localparam logic [7:0] SLAVE_ADDR = 8'h72;
  localparam int         MAX_RETRY  = 3;
  localparam int         BOOT_DLY   = 100;
  localparam int         HALF       = CLK_FREQ / (2 * I2C_FREQ);
  localparam int         GO_WIDTH   = 2 * (CLK_FREQ / I2C_FREQ);
  localparam int         BUDGET     = 20000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2c_clk, i2c_go;
  logic [15:0] i2c_reg_data;
  logic [7:0]  i2c_slave_addr, i2c_byte_num, cfg_idx;
  logic        end_ok = 1'b1;
  logic        nack = 1'b0;
  logic        hpd = 1'b0;
  logic        cfg_done, cfg_err;

  always #5 clk = ~clk;

  hdmi_cfg_sequencer #(
    .CLK_FREQ   (CLK_FREQ),
    .I2C_FREQ   (I2C_FREQ),
    .LUT_SIZE   (LUT_SIZE),
    .SLAVE_ADDR (SLAVE_ADDR),
    .MAX_RETRY  (MAX_RETRY),
    .BOOT_DLY   (BOOT_DLY)
  ) dut (
    .CLK            (clk),
    .RESET_N        (rst_n),
    .I2C_CLK        (i2c_clk),
    .I2C_GO         (i2c_go),
    .I2C_REG_DATA   (i2c_reg_data),
    .I2C_SLAVE_ADDR (i2c_slave_addr),
    .I2C_BYTE_NUM   (i2c_byte_num),
    .I2C_END_OK     (end_ok),
    .I2C_NACK       (nack),
    .HPD            (hpd),
    .CFG_DONE       (cfg_done),
    .CFG_ERR        (cfg_err),
    .CFG_IDX        (cfg_idx)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] table_ref [LUT_SIZE] = '{16'h9803, 16'h9AE0, 16'h9C30};

  // Engine behaviour knobs
  bit stuck = 1'b0;
  int nack_entry = 0;
  int nack_left = 0;

  bit eng_busy = 1'b0;
  int eng_bits = 0;

  always @(posedge i2c_clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy = 1'b0;
      end_ok   = 1'b1;
      nack     = 1'b0;
    end else if (eng_busy) begin
      if (eng_bits == 0) begin
        eng_busy = 1'b0;
        nack = (nack_left > 0) && (i2c_reg_data == table_ref[nack_entry]);
        if (nack) nack_left--;
        end_ok = 1'b1;
      end else begin
        eng_bits--;
      end
    end else if (i2c_go && !stuck) begin
      eng_busy = 1'b1;
      end_ok   = 1'b0;
      nack     = 1'b0;
      eng_bits = $urandom_range(3, 18);
    end
  end

  logic [15:0] go_log[$];
  int          go_widths[$];
  bit          go_prev = 1'b0;
  int          go_len = 0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_prev = 1'b0;
      go_len  = 0;
    end else begin
      if (i2c_go && !go_prev) begin
        go_log.push_back(i2c_reg_data);
        go_len = 0;
      end
      if (i2c_go) go_len++;
      if (!i2c_go && go_prev) go_widths.push_back(go_len);
      go_prev = i2c_go;
    end
  end

  logic [15:0] exp_log[$];
  bit          exp_done, exp_err;
  int          exp_idx;

  // Reference: each entry takes (failures+1) attempts, capped at MAX_RETRY+1, which then errors.
  task automatic build_expect(input int n_entry, input int n_nacks, input bit stuck_m);
    exp_log.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < LUT_SIZE; i++) begin
      int fails;
      int tries;
      fails = stuck_m ? MAX_RETRY + 1 : ((i == n_entry) ? n_nacks : 0);
      tries = (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
      for (int k = 0; k < tries; k++) exp_log.push_back(table_ref[i]);
      if (fails > MAX_RETRY) begin
        exp_err = 1'b1;
        exp_idx = i;
        return;
      end
    end
    exp_done = 1'b1;
    exp_idx  = LUT_SIZE;
  endtask

  function automatic int first_log_diff();
    for (int i = 0; i < go_log.size() && i < exp_log.size(); i++)
      if (go_log[i] !== exp_log[i]) return i;
    return -1;
  endfunction

  function automatic int bad_widths();
    int n = 0;
    foreach (go_widths[i]) if (go_widths[i] != GO_WIDTH) n++;
    return n;
  endfunction

  task automatic configure(input int n_entry, input int n_nacks, input bit stuck_m);
    stuck      = stuck_m;
    nack_entry = n_entry;
    nack_left  = n_nacks;
    build_expect(n_entry, n_nacks, stuck_m);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    go_log.delete();
    go_widths.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_finish(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    int t_first;
    int t_second;
    bit prev_clk;
    configure(0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (i2c_go !== 1'b0) begin miscompares++; $display("FAIL reset_go: got %0b expected 0", i2c_go); end
    vectors++; if (i2c_reg_data !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", i2c_reg_data); end
    vectors++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got done=%0b err=%0b expected 0/0", cfg_done, cfg_err); end
    vectors++; if (cfg_idx !== 8'd0) begin miscompares++; $display("FAIL reset_idx: got %0d expected 0", cfg_idx); end
    vectors++; if (i2c_clk !== 1'b0) begin miscompares++; $display("FAIL reset_i2c_clk: got %0b expected 0", i2c_clk); end
    vectors++; if (i2c_slave_addr !== SLAVE_ADDR || i2c_byte_num !== 8'd2) begin miscompares++; $display("FAIL const_ports: got addr=%h bytes=%0d expected %h/2", i2c_slave_addr, i2c_byte_num, SLAVE_ADDR); end
    go_log.delete();
    go_widths.delete();
    rst_n = 1'b1;
    n = 0; t_first = -1; t_second = -1; prev_clk = 1'b0;
    while (i2c_go !== 1'b1 && n < BOOT_DLY + 50) begin
      @(negedge clk);
      n++;
      if (i2c_clk !== prev_clk) begin
        if (t_first < 0) t_first = n;
        else if (t_second < 0) t_second = n;
      end
      prev_clk = i2c_clk;
    end
    // BOOT_DLY cycles of BOOT plus one LOAD cycle before GO is registered high
    vectors++; if (n != BOOT_DLY + 1) begin miscompares++; $display("FAIL boot_latency: got %0d expected %0d", n, BOOT_DLY + 1); end
    vectors++; if (t_second - t_first != HALF) begin miscompares++; $display("FAIL i2c_clk_half: got %0d expected %0d", t_second - t_first, HALF); end
    vectors++; if (cfg_idx !== 8'd0) begin miscompares++; $display("FAIL first_idx: got %0d expected 0", cfg_idx); end
  endtask

  task automatic test_all_ack();
    bit ok;
    configure(0, 0, 1'b0);
    do_reset();
    wait_finish(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL all_ack_timeout: got no finish expected done within %0d", BUDGET); end
    vectors++; if (go_log.size() != exp_log.size()) begin miscompares++; $display("FAIL all_ack_go_count: got %0d expected %0d", go_log.size(), exp_log.size()); end
    vectors++; if (first_log_diff() != -1) begin miscompares++; $display("FAIL all_ack_data: got mismatch at pulse %0d expected none", first_log_diff()); end
    vectors++; if (cfg_done !== exp_done || cfg_err !== exp_err) begin miscompares++; $display("FAIL all_ack_flags: got done=%0b err=%0b expected %0b/%0b", cfg_done, cfg_err, exp_done, exp_err); end
    vectors++; if (cfg_idx !== 8'(exp_idx)) begin miscompares++; $display("FAIL all_ack_idx: got %0d expected %0d", cfg_idx, exp_idx); end
    vectors++; if (bad_widths() != 0) begin miscompares++; $display("FAIL go_width: got %0d bad pulses expected 0 (width %0d)", bad_widths(), GO_WIDTH); end
  endtask

  task automatic test_retry();
    bit ok;
    configure(1, 2, 1'b0);
    do_reset();
    wait_finish(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL retry_timeout: got no finish expected done within %0d", BUDGET); end
    vectors++; if (go_log.size() != exp_log.size()) begin miscompares++; $display("FAIL retry_go_count: got %0d expected %0d", go_log.size(), exp_log.size()); end
    vectors++; if (first_log_diff() != -1) begin miscompares++; $display("FAIL retry_data: got mismatch at pulse %0d expected none", first_log_diff()); end
    vectors++; if (cfg_done !== 1'b1 || cfg_err !== 1'b0) begin miscompares++; $display("FAIL retry_flags: got done=%0b err=%0b expected 1/0", cfg_done, cfg_err); end
  endtask

  task automatic test_perm_nack();
    bit ok;
    configure(2, 1000, 1'b0);
    do_reset();
    wait_finish(ok);
    repeat (1000) @(negedge clk);
    vectors++; if (!ok) begin miscompares++; $display("FAIL perm_timeout: got no finish expected error within %0d", BUDGET); end
    vectors++; if (go_log.size() != exp_log.size()) begin miscompares++; $display("FAIL perm_go_count: got %0d expected %0d", go_log.size(), exp_log.size()); end
    vectors++; if (first_log_diff() != -1) begin miscompares++; $display("FAIL perm_data: got mismatch at pulse %0d expected none", first_log_diff()); end
    vectors++; if (cfg_err !== 1'b1 || cfg_done !== 1'b0) begin miscompares++; $display("FAIL perm_flags: got done=%0b err=%0b expected 0/1", cfg_done, cfg_err); end
    vectors++; if (cfg_idx !== 8'(exp_idx)) begin miscompares++; $display("FAIL perm_idx: got %0d expected %0d", cfg_idx, exp_idx); end
  endtask

  task automatic test_watchdog();
    bit ok;
    configure(0, 0, 1'b1);
    do_reset();
    wait_finish(ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wdog_timeout: got no finish expected error within %0d", BUDGET); end
    vectors++; if (go_log.size() != exp_log.size()) begin miscompares++; $display("FAIL wdog_go_count: got %0d expected %0d", go_log.size(), exp_log.size()); end
    vectors++; if (cfg_err !== 1'b1 || cfg_idx !== 8'(exp_idx)) begin miscompares++; $display("FAIL wdog_result: got err=%0b idx=%0d expected 1/%0d", cfg_err, cfg_idx, exp_idx); end
  endtask

  task automatic test_random();
    bit ok;
    int ne;
    int nn;
    for (int it = 0; it < 6; it++) begin
      ne = $urandom_range(0, LUT_SIZE - 1);
      nn = $urandom_range(0, MAX_RETRY + 2);
      configure(ne, nn, 1'b0);
      do_reset();
      wait_finish(ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand%0d_timeout: got no finish expected finish (entry %0d nacks %0d)", it, ne, nn); end
      vectors++; if (go_log.size() != exp_log.size()) begin miscompares++; $display("FAIL rand%0d_go_count: got %0d expected %0d", it, go_log.size(), exp_log.size()); end
      vectors++; if (first_log_diff() != -1) begin miscompares++; $display("FAIL rand%0d_data: got mismatch at pulse %0d expected none", it, first_log_diff()); end
      vectors++; if (cfg_done !== exp_done || cfg_err !== exp_err || cfg_idx !== 8'(exp_idx)) begin
        miscompares++;
        $display("FAIL rand%0d_result: got done=%0b err=%0b idx=%0d expected %0b/%0b/%0d", it, cfg_done, cfg_err, cfg_idx, exp_done, exp_err, exp_idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    configure(0, 0, 1'b0);
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < BUDGET && !hit; i++) begin
      @(negedge clk);
      if (go_log.size() == 2 && go_widths.size() == 2) hit = 1'b1;
    end
    repeat (5) @(negedge clk);
    vectors++; if (!hit || end_ok !== 1'b0) begin miscompares++; $display("FAIL mid_setup: got reached=%0b end_ok=%0b expected 1/0", hit, end_ok); end
    rst_n = 1'b0;
    #1;
    vectors++; if (i2c_go !== 1'b0 || i2c_reg_data !== 16'h0 || i2c_clk !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_out: got go=%0b data=%h clk=%0b expected 0/0000/0", i2c_go, i2c_reg_data, i2c_clk);
    end
    vectors++; if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_idx !== 8'd0) begin
      miscompares++;
      $display("FAIL mid_reset_flags: got done=%0b err=%0b idx=%0d expected 0/0/0", cfg_done, cfg_err, cfg_idx);
    end
    repeat (3) @(negedge clk);
    go_log.delete();
    go_widths.delete();
    rst_n = 1'b1;
    wait_finish(ok);
    vectors++; if (!ok || cfg_done !== 1'b1) begin miscompares++; $display("FAIL mid_restart_done: got done=%0b expected 1", cfg_done); end
    vectors++; if (go_log.size() != exp_log.size() || first_log_diff() != -1) begin
      miscompares++;
      $display("FAIL mid_restart_seq: got %0d pulses diff@%0d expected %0d pulses from entry 0", go_log.size(), first_log_diff(), exp_log.size());
    end
  endtask

  task automatic test_hpd();
    bit ok;
    configure(0, 0, 1'b0);
    hpd = 1'b0;
    do_reset();
    wait_finish(ok);
    vectors++; if (!ok || cfg_done !== 1'b1) begin miscompares++; $display("FAIL hpd_pre_done: got done=%0b expected 1", cfg_done); end
    go_log.delete();
    go_widths.delete();
    hpd = 1'b1;
`ifdef HDMI_CFG_HPD_EN
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cfg_done === 1'b0) ok = 1'b1;
    end
    vectors++; if (!ok || cfg_idx !== 8'd0) begin miscompares++; $display("FAIL hpd_clear: got done=%0b idx=%0d expected 0/0", cfg_done, cfg_idx); end
    wait_finish(ok);
    vectors++; if (!ok || cfg_done !== 1'b1 || cfg_idx !== 8'(LUT_SIZE)) begin
      miscompares++;
      $display("FAIL hpd_rerun: got done=%0b idx=%0d expected 1/%0d", cfg_done, cfg_idx, LUT_SIZE);
    end
    vectors++; if (go_log.size() != exp_log.size() || first_log_diff() != -1) begin
      miscompares++;
      $display("FAIL hpd_rerun_seq: got %0d pulses diff@%0d expected %0d", go_log.size(), first_log_diff(), exp_log.size());
    end
`else
    repeat (500) @(negedge clk);
    vectors++; if (cfg_done !== 1'b1 || cfg_idx !== 8'(LUT_SIZE)) begin
      miscompares++;
      $display("FAIL hpd_ignored: got done=%0b idx=%0d expected 1/%0d", cfg_done, cfg_idx, LUT_SIZE);
    end
    vectors++; if (go_log.size() != 0) begin miscompares++; $display("FAIL hpd_no_go: got %0d pulses expected 0", go_log.size()); end
`endif
    hpd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_ack();
    test_retry();
    test_perm_nack();
    test_watchdog();
    test_random();
    test_reset_mid();
    test_hpd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hdmi_cfg_sequencer.md
HDMI_CFG_SEQUENCER -- requirements
Module: hdmi_cfg_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CLK_FREQ, 50_000_000, system clock Hz; I2C_FREQ, 20_000, I2C bit-phase tick rate Hz; LUT_SIZE, 31, number of table entries; SLAVE_ADDR, 8'h72, 8-bit write address; MAX_RETRY, 3, retries per entry; BOOT_DLY, 1_000_000, CLK cycles before the first entry.
REQ-002 CLK  in  1  system clock, all state on rising edge.
REQ-003 RESET_N  in  1  reset; asynchronous, active-low.
REQ-004 I2C_CLK  out  1  square-wave clock for the I2C write engine, toggles every CLK_FREQ/(2*I2C_FREQ) CLK cycles.
REQ-005 I2C_GO  out  1  start request to the engine.
REQ-006 I2C_REG_DATA  out  16  {register, value} for the current entry.
REQ-007 I2C_SLAVE_ADDR  out  8  equals SLAVE_ADDR.
REQ-008 I2C_BYTE_NUM  out  8  constant 8'd2.
REQ-009 I2C_END_OK  in  1  engine idle/done flag, I2C_CLK domain.
REQ-010 I2C_NACK  in  1  engine NACK flag (high = slave did not acknowledge), I2C_CLK domain.
REQ-011 HPD  in  1  HDMI hot-plug detect, asynchronous.
REQ-012 CFG_DONE  out  1  all entries written.
REQ-013 CFG_ERR  out  1  an entry exhausted its retries.
REQ-014 CFG_IDX  out  8  current table index.

Function
REQ-015 I2C_END_OK, I2C_NACK and HPD SHALL each pass through a 2-flop synchronizer before use.
REQ-016 The FSM SHALL have states BOOT, LOAD, GO_HI, GO_LO, WAIT_BUSY, WAIT_DONE, CHECK, DONE, ERROR.
REQ-017 BOOT SHALL count BOOT_DLY CLK cycles with CFG_IDX=0, then go to LOAD.
REQ-018 LOAD SHALL register I2C_REG_DATA from the table entry at CFG_IDX, clear the per-entry retry counter on the first attempt only, and go to GO_HI.
REQ-019 GO_HI SHALL hold I2C_GO=1 for two full I2C_CLK periods, then go to GO_LO.
REQ-020 GO_LO SHALL drive I2C_GO=0 and go to WAIT_BUSY.
REQ-021 WAIT_BUSY SHALL wait for synchronized END_OK=0, then go to WAIT_DONE.
REQ-022 WAIT_DONE SHALL wait for synchronized END_OK=1, sample synchronized NACK, and go to CHECK.
REQ-023 CHECK on ACK SHALL increment CFG_IDX; go to DONE if the new index equals LUT_SIZE, else go to LOAD.
REQ-024 CHECK on NACK with retry count < MAX_RETRY SHALL increment the retry count and return to LOAD at the same index.
REQ-025 CHECK on NACK with retry count = MAX_RETRY SHALL go to ERROR.
REQ-026 DONE SHALL assert CFG_DONE=1 and hold.
REQ-027 ERROR SHALL assert CFG_ERR=1 and hold, with CFG_IDX frozen at the failing entry.
REQ-028 A watchdog SHALL count CLK cycles in WAIT_BUSY/WAIT_DONE; reaching 64 I2C_CLK periods SHALL count as a NACK.
REQ-029 I2C_GO SHALL be 0 in every state except GO_HI.
REQ-030 The retry counter SHALL be $clog2(MAX_RETRY+1) bits and CFG_IDX SHALL saturate at LUT_SIZE with no wrap.

Reset
REQ-031 On RESET_N=0: state=BOOT, I2C_GO=0, I2C_REG_DATA=0, CFG_DONE=0, CFG_ERR=0, CFG_IDX=0, I2C_CLK=0, and all counters and synchronizers cleared.
REQ-032 Reset asserted mid-transfer SHALL abort immediately; the sequence SHALL restart from BOOT after release.

Configuration
REQ-033 With HDMI_CFG_HPD_EN defined, a synchronized HPD rising edge in DONE or ERROR SHALL clear CFG_DONE/CFG_ERR and CFG_IDX and go to BOOT.
REQ-034 With HDMI_CFG_HPD_EN defined, an HPD edge in any other state SHALL be latched and acted upon on entry to DONE or ERROR.
REQ-035 Without HDMI_CFG_HPD_EN, HPD SHALL be ignored, DONE and ERROR SHALL be terminal until reset, and the HPD synchronizer SHALL be absent.

Structure
REQ-036 A package hdmi_cfg_pkg SHALL hold the FSM state enum, the BYTE_NUM constant 8'd2 and the watchdog constant 64.
REQ-037 The table SHALL be a sub-module hdmi_cfg_rom: combinational, 8-bit index in, 16-bit {reg, value} out, returning 16'h0000 beyond LUT_SIZE-1.

Verification
REQ-038 BOOT_DLY=100 and LUT_SIZE=3 with an always-ACK engine model -> exactly 3 GO pulses, CFG_DONE=1, CFG_IDX=3, CFG_ERR=0.
REQ-039 NACK on the first 2 attempts of entry 1 -> 3 GO pulses carry identical I2C_REG_DATA, then the sequence continues and CFG_DONE=1.
REQ-040 Permanent NACK at entry 2 with MAX_RETRY=3 -> 4 attempts, then CFG_ERR=1, CFG_IDX=2, no further GO.
REQ-041 Engine model never drops END_OK -> watchdog counts as a NACK on each attempt, retries occur, and CFG_ERR=1 results.
REQ-042 RESET_N pulsed low during WAIT_DONE of entry 1 -> outputs at reset values, and after release the sequence restarts at entry 0.
REQ-043 With HDMI_CFG_HPD_EN, an HPD rising edge after CFG_DONE -> CFG_DONE=0, and the full table is rewritten; without the macro, no response.
